// File: rtl/halt_controller.sv
// Simulation-termination sequencer: latches the ebreak (or watchdog) trap data,
// stalls the core, drains pending stores, pulses exit once and then halts.
module halt_controller #(
  parameter int          XLEN           = 64,
  parameter int          WATCHDOG_LIMIT = 1000000,
  parameter int          DRAIN_MAX      = 16,
  parameter logic [63:0] TIMEOUT_CODE   = 64'hDEAD_0000_0000_0001
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            commit_valid,
  input  logic            commit_ebreak,
  input  logic [XLEN-1:0] commit_pc,
  input  logic [31:0]     commit_inst,
  input  logic [XLEN-1:0] a0_value,
  input  logic            mem_wr_pending,
  output logic            stall_req,
  output logic            exit,
  output logic [XLEN-1:0] exit_pc,
  output logic [31:0]     exit_inst,
  output logic [XLEN-1:0] exit_a0,
  output logic            bad_trap,
  output logic            timeout,
  output logic            drain_overflow,
  output logic            halted,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_REPORT = 2'd2,
    ST_HALT   = 2'd3
  } state_t;

  localparam int WD_W = (WATCHDOG_LIMIT > 1) ? $clog2(WATCHDOG_LIMIT + 1) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(WATCHDOG_LIMIT);
  localparam logic [WD_W-1:0] WD_EXP = WD_W'((WATCHDOG_LIMIT > 0) ? WATCHDOG_LIMIT - 1 : 0);
  localparam int DR_W = $clog2(DRAIN_MAX + 1);
  localparam logic [DR_W-1:0] DR_LAST = DR_W'(DRAIN_MAX - 1);

  state_t            state_q, state_d;
  logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
  logic [DR_W-1:0]   drain_cnt_q, drain_cnt_d;
  logic [XLEN-1:0]   last_pc_q, last_pc_d;
  logic [31:0]       last_inst_q, last_inst_d;
  logic [XLEN-1:0]   exit_pc_q, exit_pc_d;
  logic [31:0]       exit_inst_q, exit_inst_d;
  logic [XLEN-1:0]   exit_a0_q, exit_a0_d;
  logic              bad_trap_q, bad_trap_d;
  logic              timeout_q, timeout_d;
  logic              drain_overflow_q, drain_overflow_d;
  logic              wd_expire;

  // A commit in the expiry cycle wins, so expiry requires an idle cycle.
  assign wd_expire = (WATCHDOG_LIMIT != 0) && (wd_cnt_q == WD_EXP) && !commit_valid;

  always_comb begin
    state_d          = state_q;
    wd_cnt_d         = wd_cnt_q;
    drain_cnt_d      = drain_cnt_q;
    last_pc_d        = last_pc_q;
    last_inst_d      = last_inst_q;
    exit_pc_d        = exit_pc_q;
    exit_inst_d      = exit_inst_q;
    exit_a0_d        = exit_a0_q;
    bad_trap_d       = bad_trap_q;
    timeout_d        = timeout_q;
    drain_overflow_d = drain_overflow_q;
    case (state_q)
      ST_RUN: begin
        drain_cnt_d = '0;
        if (commit_valid) begin
          wd_cnt_d    = '0;
          last_pc_d   = commit_pc;
          last_inst_d = commit_inst;
        end else if (wd_cnt_q != WD_MAX) begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
        if (commit_valid && commit_ebreak) begin
          exit_pc_d   = commit_pc;
          exit_inst_d = commit_inst;
          exit_a0_d   = a0_value;
          bad_trap_d  = (a0_value != '0);
          timeout_d   = 1'b0;
          state_d     = ST_DRAIN;
        end else if (wd_expire) begin
          exit_pc_d   = last_pc_q;
          exit_inst_d = last_inst_q;
          exit_a0_d   = XLEN'(TIMEOUT_CODE);
          bad_trap_d  = 1'b1;
          timeout_d   = 1'b1;
          state_d     = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        drain_cnt_d = drain_cnt_q + 1'b1;
        if (!mem_wr_pending) begin
          state_d = ST_REPORT;
        end else if (drain_cnt_q == DR_LAST) begin
          drain_overflow_d = 1'b1;
          state_d          = ST_REPORT;
        end
      end
      ST_REPORT: state_d = ST_HALT;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= ST_RUN;
      wd_cnt_q         <= '0;
      drain_cnt_q      <= '0;
      last_pc_q        <= '0;
      last_inst_q      <= '0;
      exit_pc_q        <= '0;
      exit_inst_q      <= '0;
      exit_a0_q        <= '0;
      bad_trap_q       <= 1'b0;
      timeout_q        <= 1'b0;
      drain_overflow_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      wd_cnt_q         <= wd_cnt_d;
      drain_cnt_q      <= drain_cnt_d;
      last_pc_q        <= last_pc_d;
      last_inst_q      <= last_inst_d;
      exit_pc_q        <= exit_pc_d;
      exit_inst_q      <= exit_inst_d;
      exit_a0_q        <= exit_a0_d;
      bad_trap_q       <= bad_trap_d;
      timeout_q        <= timeout_d;
      drain_overflow_q <= drain_overflow_d;
    end
  end

  assign stall_req      = (state_q != ST_RUN);
  assign exit           = (state_q == ST_REPORT);
  assign halted         = (state_q == ST_HALT);
  assign exit_pc        = exit_pc_q;
  assign exit_inst      = exit_inst_q;
  assign exit_a0        = exit_a0_q;
  assign bad_trap       = bad_trap_q;
  assign timeout        = timeout_q;
  assign drain_overflow = drain_overflow_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_halt_controller.sv
// Directed bench for halt_controller: expected exit records and their cycles are
// queued when the trigger is driven and checked when exit pulses.
module tb_halt_controller;

  localparam int          XLEN    = 64;
  localparam int          WD_LIM  = 100;
  localparam int          DMAX    = 16;
  localparam logic [63:0] TO_CODE = 64'hDEAD_0000_0000_0001;
  localparam int          RW      = XLEN + 32 + XLEN + 3;

  logic            clock = 1'b0;
  logic            reset_n;
  logic            commit_valid, commit_ebreak, mem_wr_pending;
  logic [XLEN-1:0] commit_pc, a0_value;
  logic [31:0]     commit_inst;
  logic            stall_req, exit, bad_trap, timeout, drain_overflow, halted;
  logic [XLEN-1:0] exit_pc, exit_a0;
  logic [31:0]     exit_inst;
  logic [1:0]      dbg_state;

  int cyc      = 0;
  int n_checks = 0;
  int n_fail   = 0;
  int n, c0, c2;
  logic [RW-1:0] exp_q[$];
  int            exp_cyc_q[$];
  logic [RW-1:0] mon_rec;
  int            mon_cyc;

  halt_controller #(
    .XLEN(XLEN), .WATCHDOG_LIMIT(WD_LIM), .DRAIN_MAX(DMAX), .TIMEOUT_CODE(TO_CODE)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .commit_valid(commit_valid), .commit_ebreak(commit_ebreak),
    .commit_pc(commit_pc), .commit_inst(commit_inst), .a0_value(a0_value),
    .mem_wr_pending(mem_wr_pending),
    .stall_req(stall_req), .exit(exit), .exit_pc(exit_pc), .exit_inst(exit_inst),
    .exit_a0(exit_a0), .bad_trap(bad_trap), .timeout(timeout),
    .drain_overflow(drain_overflow), .halted(halted), .dbg_state(dbg_state)
  );

  // Clock / reset block
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  function automatic logic [RW-1:0] rec(input logic [63:0] pc, input logic [31:0] inst,
                                        input logic [63:0] a0, input logic bad,
                                        input logic to, input logic ovf);
    return {pc, inst, a0, bad, to, ovf};
  endfunction

  task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic tick(input int k);
    repeat (k) @(posedge clock);
    #1;
  endtask

  task automatic idle();
    commit_valid  = 1'b0;
    commit_ebreak = 1'b0;
  endtask

  task automatic commit(input logic [63:0] pc, input logic [31:0] inst,
                        input logic [63:0] a0, input logic ebreak);
    commit_valid  = 1'b1;
    commit_ebreak = ebreak;
    commit_pc     = pc;
    commit_inst   = inst;
    a0_value      = a0;
  endtask

  task automatic expect_exit(input logic [RW-1:0] r, input int at_cyc);
    exp_q.push_back(r);
    exp_cyc_q.push_back(at_cyc);
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_stall"}, stall_req, 0);
    chk({tag, "_exit"}, exit, 0);
    chk({tag, "_halted"}, halted, 0);
    chk({tag, "_exit_pc"}, exit_pc, 0);
    chk({tag, "_exit_inst"}, exit_inst, 0);
    chk({tag, "_exit_a0"}, exit_a0, 0);
    chk({tag, "_bad_trap"}, bad_trap, 0);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_overflow"}, drain_overflow, 0);
    chk({tag, "_state"}, dbg_state, 0);
  endtask

  // Asynchronous reset mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset(input string tag);
    #2;
    reset_n = 1'b0;
    idle();
    #1;
    check_cleared(tag);
    tick(2);
    reset_n = 1'b1;
    tick(1);
  endtask

  // Scoreboard: every exit pulse must match the head of the expected queue.
  always @(negedge clock) begin
    if (reset_n === 1'b1 && exit === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_exit", exit, 0);
      end else begin
        mon_rec = exp_q.pop_front();
        mon_cyc = exp_cyc_q.pop_front();
        chk("exit_record", rec(exit_pc, exit_inst, exit_a0, bad_trap, timeout, drain_overflow), mon_rec);
        chk("exit_cycle", cyc, mon_cyc);
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    idle();
    commit_pc = '0; commit_inst = '0; a0_value = '0; mem_wr_pending = 1'b0;
    tick(3);
    check_cleared("reset");
    reset_n = 1'b1;
    tick(1);

    // Clean ebreak, a0=0, no pending stores
    commit(64'h8000_0010, 32'h0010_0073, 64'h0, 1'b1);
    n = cyc;
    expect_exit(rec(64'h8000_0010, 32'h0010_0073, 64'h0, 1'b0, 1'b0, 1'b0), n + 2);
    tick(1); idle();
    chk("t1_stall_n1", stall_req, 1);
    chk("t1_exit_n1", exit, 0);
    chk("t1_state_n1", dbg_state, 1);
    tick(1);
    chk("t1_exit_n2", exit, 1);
    chk("t1_halted_n2", halted, 0);
    tick(1);
    chk("t1_halted_n3", halted, 1);
    chk("t1_exit_n3", exit, 0);
    chk("t1_stall_n3", stall_req, 1);
    tick(3);
    chk("t1_halt_hold_pc", exit_pc, 64'h8000_0010);
    chk("t1_halt_hold", halted, 1);
    do_reset("rst_in_halt");

    // Bad trap with stores pending for 5 drain cycles
    commit(64'h8000_0020, 32'h0010_0073, 64'h1, 1'b1);
    mem_wr_pending = 1'b1;
    n = cyc;
    expect_exit(rec(64'h8000_0020, 32'h0010_0073, 64'h1, 1'b1, 1'b0, 1'b0), n + 7);
    for (int i = 1; i <= 5; i++) begin
      tick(1); idle();
      chk("t2_stall_pending", stall_req, 1);
      chk("t2_no_exit_pending", exit, 0);
    end
    tick(1);
    mem_wr_pending = 1'b0;
    chk("t2_stall_drop", stall_req, 1);
    tick(1);
    chk("t2_exit", exit, 1);
    chk("t2_stall_exit", stall_req, 1);
    tick(1);
    chk("t2_halted", halted, 1);
    do_reset("rst_t2");

    // Stores never drain: forced exit after DRAIN_MAX cycles
    commit(64'h8000_0100, 32'h0010_0073, 64'h55, 1'b1);
    mem_wr_pending = 1'b1;
    n = cyc;
    expect_exit(rec(64'h8000_0100, 32'h0010_0073, 64'h55, 1'b1, 1'b0, 1'b1), n + 1 + DMAX);
    tick(1); idle();
    tick(DMAX - 1);
    chk("t3_no_exit_last_drain", exit, 0);
    chk("t3_no_ovf_yet", drain_overflow, 0);
    tick(1);
    chk("t3_exit", exit, 1);
    chk("t3_ovf", drain_overflow, 1);
    tick(1);
    chk("t3_halted", halted, 1);
    mem_wr_pending = 1'b0;
    do_reset("rst_t3");

    // Commits during DRAIN are ignored
    commit(64'h8000_0030, 32'h0010_0073, 64'h0, 1'b1);
    mem_wr_pending = 1'b1;
    n = cyc;
    expect_exit(rec(64'h8000_0030, 32'h0010_0073, 64'h0, 1'b0, 1'b0, 1'b0), n + 5);
    for (int i = 1; i <= 3; i++) begin
      tick(1);
      commit(64'h8000_1000 + 64'(i * 4), 32'h0010_0073, 64'(i), 1'b1);
      chk("t5_pc_frozen", exit_pc, 64'h8000_0030);
      chk("t5_a0_frozen", exit_a0, 64'h0);
    end
    tick(1);
    mem_wr_pending = 1'b0;
    tick(1);
    chk("t5_exit", exit, 1);
    chk("t5_exit_pc", exit_pc, 64'h8000_0030);
    tick(1); idle();
    tick(3);
    chk("t5_halted", halted, 1);
    do_reset("rst_t5");

    // Reset while in DRAIN, then a fresh ebreak
    commit(64'h8000_0040, 32'h0010_0073, 64'h7, 1'b1);
    mem_wr_pending = 1'b1;
    tick(1); idle();
    tick(1);
    chk("t6_in_drain", dbg_state, 1);
    do_reset("rst_in_drain");
    mem_wr_pending = 1'b0;
    commit(64'h8000_0050, 32'h0010_0073, 64'h0, 1'b1);
    n = cyc;
    expect_exit(rec(64'h8000_0050, 32'h0010_0073, 64'h0, 1'b0, 1'b0, 1'b0), n + 2);
    tick(1); idle();
    tick(3);
    chk("t6_halted", halted, 1);
    chk("t6_exit_pc", exit_pc, 64'h8000_0050);
    do_reset("rst_t6");

    // Watchdog: a commit in the expiry cycle rescues, then a real timeout
    commit(64'h8000_0300, 32'h0000_0013, 64'h0, 1'b0);
    c0 = cyc;
    tick(1); idle();
    tick(WD_LIM - 2);
    tick(1);
    commit(64'h8000_0400, 32'h0000_0013, 64'h1234, 1'b0);
    chk("t4_rescue_state", dbg_state, 0);
    c2 = cyc;
    tick(1); idle();
    chk("t4_rescued_run", dbg_state, 0);
    chk("t4_rescued_stall", stall_req, 0);
    expect_exit(rec(64'h8000_0400, 32'h0000_0013, TO_CODE, 1'b1, 1'b1, 1'b0), c2 + WD_LIM + 2);
    tick(WD_LIM - 1);
    chk("t4_expiry_cycle_run", dbg_state, 0);
    tick(1);
    chk("t4_drain", dbg_state, 1);
    chk("t4_timeout_latched", timeout, 1);
    tick(1);
    chk("t4_exit", exit, 1);
    chk("t4_exit_a0", exit_a0, TO_CODE);
    tick(1);
    chk("t4_halted", halted, 1);
    chk("t4_rescue_gap", c2 - c0, WD_LIM);

    tick(3);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
